// File: rtl/cpu_cycle_controller_if.sv
// Avalon-style memory port shared by instruction fetch and load/store access.
//   read, write    : access strobes (held while waitrequest is high)
//   address        : byte address of the access
//   byteenable     : active byte lanes
//   writedata      : store data
//   waitrequest    : memory stall; an access completes in the cycle it is low
interface cpu_cycle_controller_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (
        output read,
        output write,
        output address,
        output byteenable,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  byteenable,
        input  writedata,
        output waitrequest
    );
endinterface

// File: rtl/cpu_cycle_controller.sv
// Phase sequencer for the multicycle MIPS core.
// Generates fetch/exec1/exec2 strobes, arbitrates the single memory port between
// instruction fetch and load/store, stretches phases on waitrequest / unit_busy,
// and parks in a halted state once the PC reports pc_halt.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   pc_address, pc_halt : current PC and its halt indication
//   mem_read_req,
//   mem_write_req       : decoded load / store (meaningful in EXEC1)
//   data_address,
//   store_data,
//   store_byteenable    : load/store address, store data and lanes
//   unit_busy           : multiply/divide unit still working (EXEC2)
//   mem                 : memory port (master side)
//   fetch, exec1, exec2 : phase strobes
//   ir_write_en         : latch readdata into the instruction register
//   stall               : current phase is held
//   active              : CPU running
//   retired             : completed instruction count
module cpu_cycle_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   pc_address,
    input  logic                          pc_halt,
    input  logic                          mem_read_req,
    input  logic                          mem_write_req,
    input  logic [31:0]                   data_address,
    input  logic [31:0]                   store_data,
    input  logic [3:0]                    store_byteenable,
    input  logic                          unit_busy,
    cpu_cycle_controller_if.master        mem,
    output logic                          fetch,
    output logic                          exec1,
    output logic                          exec2,
    output logic                          ir_write_en,
    output logic                          stall,
    output logic                          active,
    output logic [31:0]                   retired
);

    typedef enum logic [1:0] {
        StFetch,
        StExec1,
        StExec2,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        data_access;

    assign data_access = mem_read_req | mem_write_req;

    always_comb begin
        state_d         = state_q;
        retired_d       = retired_q;
        fetch           = 1'b0;
        exec1           = 1'b0;
        exec2           = 1'b0;
        ir_write_en     = 1'b0;
        stall           = 1'b0;
        active          = 1'b1;
        mem.read        = 1'b0;
        mem.write       = 1'b0;
        mem.address     = '0;
        mem.byteenable  = '0;
        mem.writedata   = '0;

        // Reset masks every output so an in-flight access is dropped immediately.
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    if (pc_halt) begin
                        state_d = StHalted;
                    end else begin
                        mem.read       = 1'b1;
                        mem.address    = pc_address;
                        mem.byteenable = 4'b1111;
                        if (mem.waitrequest) begin
                            stall = 1'b1;
                        end else begin
                            fetch       = 1'b1;
                            ir_write_en = 1'b1;
                            state_d     = StExec1;
                        end
                    end
                end
                StExec1: begin
                    exec1 = 1'b1;
                    // Load wins when the decoder flags both.
                    if (mem_read_req) begin
                        mem.read       = 1'b1;
                        mem.address    = data_address;
                        mem.byteenable = 4'b1111;
                    end else if (mem_write_req) begin
                        mem.write      = 1'b1;
                        mem.address    = data_address;
                        mem.byteenable = store_byteenable;
                        mem.writedata  = store_data;
                    end
                    if (data_access && mem.waitrequest) begin
                        stall = 1'b1;
                    end else begin
                        state_d = StExec2;
                    end
                end
                StExec2: begin
                    exec2 = 1'b1;
                    if (unit_busy) begin
                        stall = 1'b1;
                    end else begin
                        state_d   = StFetch;
                        retired_d = retired_q + 32'd1;
                    end
                end
                StHalted: begin
                    active = 1'b0;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

    // The vector is owned by the PC; only its word alignment is checked here.
    a_vector_aligned: assert property (@(posedge clk) RESET_VECTOR[1:0] == 2'b00);
    a_one_strobe: assert property (@(posedge clk) !(mem.read && mem.write));

endmodule

// File: tb/tb_cpu_cycle_controller.sv
// Bench for cpu_cycle_controller: instruction-level random plans are expanded into
// per-cycle stimulus plus expected outputs; a negedge monitor pops and compares.
module tb_cpu_cycle_controller;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        halt;
        logic        wait_r;
        logic        rd_req;
        logic        wr_req;
        logic [31:0] da;
        logic [31:0] sd;
        logic [3:0]  sbe;
        logic        busy;
    } in_t;

    typedef struct {
        logic        fetch;
        logic        exec1;
        logic        exec2;
        logic        ir;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        stall;
        logic        active;
        logic [31:0] ret;
        bit          chk_ret;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_address;
    logic        pc_halt;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [31:0] data_address;
    logic [31:0] store_data;
    logic [3:0]  store_byteenable;
    logic        unit_busy;
    logic        fetch, exec1, exec2, ir_write_en, stall, active;
    logic [31:0] retired;

    cpu_cycle_controller_if mem_bus ();

    cpu_cycle_controller dut (
        .clk              (clk),
        .reset            (reset),
        .pc_address       (pc_address),
        .pc_halt          (pc_halt),
        .mem_read_req     (mem_read_req),
        .mem_write_req    (mem_write_req),
        .data_address     (data_address),
        .store_data       (store_data),
        .store_byteenable (store_byteenable),
        .unit_busy        (unit_busy),
        .mem              (mem_bus.master),
        .fetch            (fetch),
        .exec1            (exec1),
        .exec2            (exec2),
        .ir_write_en      (ir_write_en),
        .stall            (stall),
        .active           (active),
        .retired          (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle_n = 0;
    logic [31:0] r_model = '0;   // instructions retired so far, per the model

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle_n, act, want);
        end
    endtask

    function automatic logic rb();
        return $urandom_range(0, 1) == 1;
    endfunction

    function automatic in_t rnd_in();
        in_t i;
        i.rst    = 1'b0;
        i.pc     = $urandom();
        i.halt   = rb();
        i.wait_r = rb();
        i.rd_req = rb();
        i.wr_req = rb();
        i.da     = $urandom();
        i.sd     = $urandom();
        i.sbe    = 4'($urandom());
        i.busy   = rb();
        return i;
    endfunction

    function automatic exp_t base_exp();
        exp_t e;
        e.fetch = 0; e.exec1 = 0; e.exec2 = 0; e.ir = 0; e.rd = 0; e.wr = 0;
        e.addr = '0; e.be = '0; e.wd = '0; e.stall = 0; e.active = 1;
        e.ret = r_model; e.chk_ret = 1;
        return e;
    endfunction

    task automatic step(input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        reset               = i.rst;
        pc_address          = i.pc;
        pc_halt             = i.halt;
        mem_bus.waitrequest = i.wait_r;
        mem_read_req        = i.rd_req;
        mem_write_req       = i.wr_req;
        data_address        = i.da;
        store_data          = i.sd;
        store_byteenable    = i.sbe;
        unit_busy           = i.busy;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n, input bit unknown_ret);
        for (int k = 0; k < n; k++) begin
            in_t  i = rnd_in();
            exp_t e = base_exp();
            i.rst = 1'b1;
            e.chk_ret = !(unknown_ret && k == 0);
            step(i, e);
            r_model = '0;
        end
    endtask

    task automatic do_fetch(input logic [31:0] pc, input int fw);
        for (int k = 0; k <= fw; k++) begin
            in_t  i = rnd_in();
            exp_t e = base_exp();
            i.halt = 1'b0;
            i.pc = pc;
            i.wait_r = (k < fw);
            e.rd = 1; e.addr = pc; e.be = 4'hF;
            e.stall = (k < fw);
            e.fetch = (k == fw);
            e.ir    = (k == fw);
            step(i, e);
        end
    endtask

    // kind: 0 none, 1 load, 2 store, 3 both requested. stop_early leaves it stalled.
    task automatic do_exec1(input int kind, input logic [31:0] da, input logic [31:0] sd,
                            input logic [3:0] sbe, input int aw, input bit stop_early);
        logic rq = (kind == 1 || kind == 3);
        logic wq = (kind == 2 || kind == 3);
        if (kind == 0) begin
            in_t  i = rnd_in();
            exp_t e = base_exp();
            i.rd_req = 0; i.wr_req = 0;
            e.exec1 = 1;
            step(i, e);
        end else begin
            for (int k = 0; k < (stop_early ? aw : aw + 1); k++) begin
                in_t  i = rnd_in();
                exp_t e = base_exp();
                i.rd_req = rq; i.wr_req = wq; i.da = da; i.sd = sd; i.sbe = sbe;
                i.wait_r = (k < aw);
                e.exec1 = 1;
                e.addr  = da;
                e.stall = (k < aw);
                if (rq) begin
                    e.rd = 1; e.be = 4'hF;
                end else begin
                    e.wr = 1; e.be = sbe; e.wd = sd;
                end
                step(i, e);
            end
        end
    endtask

    task automatic do_exec2(input int bw);
        for (int k = 0; k <= bw; k++) begin
            in_t  i = rnd_in();
            exp_t e = base_exp();
            i.busy = (k < bw);
            e.exec2 = 1;
            e.stall = (k < bw);
            step(i, e);
        end
        r_model = r_model + 32'd1;
    endtask

    task automatic do_instr(input logic [31:0] pc, input int fw, input int kind,
                            input logic [31:0] da, input logic [31:0] sd, input logic [3:0] sbe,
                            input int aw, input int bw);
        do_fetch(pc, fw);
        do_exec1(kind, da, sd, sbe, aw, 1'b0);
        do_exec2(bw);
    endtask

    task automatic do_halt(input int nh);
        in_t  i = rnd_in();
        exp_t e = base_exp();
        i.halt = 1'b1;
        step(i, e);
        for (int k = 0; k < nh; k++) begin
            i = rnd_in();
            e = base_exp();
            e.active = 0;
            step(i, e);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the queued record.
    exp_t m_e;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            cycle_n++;
            chk("fetch", 32'(fetch), 32'(m_e.fetch));
            chk("exec1", 32'(exec1), 32'(m_e.exec1));
            chk("exec2", 32'(exec2), 32'(m_e.exec2));
            chk("ir_write_en", 32'(ir_write_en), 32'(m_e.ir));
            chk("read", 32'(mem_bus.read), 32'(m_e.rd));
            chk("write", 32'(mem_bus.write), 32'(m_e.wr));
            chk("address", mem_bus.address, m_e.addr);
            chk("byteenable", 32'(mem_bus.byteenable), 32'(m_e.be));
            chk("writedata", mem_bus.writedata, m_e.wd);
            chk("stall", 32'(stall), 32'(m_e.stall));
            chk("active", 32'(active), 32'(m_e.active));
            if (m_e.chk_ret) chk("retired", retired, m_e.ret);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; pc_address = '0; pc_halt = 1'b0; mem_bus.waitrequest = 1'b0;
        mem_read_req = 1'b0; mem_write_req = 1'b0; data_address = '0; store_data = '0;
        store_byteenable = '0; unit_busy = 1'b0;

        do_reset(2, 1'b1);
        // Plain back-to-back instructions: retired reaches 4 after 12 cycles.
        for (int n = 0; n < 4; n++) do_instr(32'h1000 + 32'(n * 4), 0, 0, '0, '0, '0, 0, 0);
        // Fetch held for 3 wait cycles.
        do_instr(32'h2000, 3, 0, '0, '0, '0, 0, 0);
        // Store with one wait cycle.
        do_instr(32'h2004, 0, 2, 32'h00001004, 32'hDEADBEEF, 4'b0011, 1, 0);
        // Load and store both requested: load wins.
        do_instr(32'h2008, 0, 3, 32'h00003000, 32'h12345678, 4'b0101, 0, 0);
        // Multicycle unit busy for 5 cycles.
        do_instr(32'h200C, 0, 0, '0, '0, '0, 0, 5);

        for (int n = 0; n < 150; n++) begin
            do_instr($urandom() & 32'hFFFF_FFFC, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), $urandom(), $urandom(), 4'($urandom()),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a stalled load.
        do_fetch(32'h3000, 1);
        do_exec1(1, 32'h0000_4000, '0, '0, 2, 1'b1);
        do_reset(1, 1'b0);
        do_instr(32'h3004, 1, 1, 32'h0000_4000, '0, '0, 1, 1);

        // Halt, then stay halted until reset brings the CPU back.
        do_halt(6);
        do_reset(1, 1'b0);
        do_instr(32'h3008, 0, 2, 32'h5000, 32'hCAFEF00D, 4'b1000, 0, 0);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
